// File: rtl/dpram_fifo_ctrl_pkg.sv
// Shared constants for the dual-port-RAM FIFO controller and its output buffer.
package dpram_fifo_ctrl_pkg;

   // Default RAM geometry: 64 words of 8 bits.
   localparam int FIFO_ADDR_W = 6;
   localparam int FIFO_DATA_W = 8;

   // Output buffer hides the RAM's one-cycle registered read.
   localparam int OBUF_DEPTH  = 2;
   localparam int OBUF_CNT_W  = 2;

endpackage

// File: rtl/fifo_out_buf.sv
// Two-entry register buffer that holds words read from the RAM.
// The head entry always sits in e0 so rd_data is a direct register output.
module fifo_out_buf
   import dpram_fifo_ctrl_pkg::*;
#(
   parameter int DATA_W = FIFO_DATA_W
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  push,
   input  logic [DATA_W-1:0]     push_data,
   input  logic                  pop,
   output logic [DATA_W-1:0]     head,
   output logic [OBUF_CNT_W-1:0] cnt
);

   localparam logic [OBUF_CNT_W-1:0] CNT_FULL = OBUF_CNT_W'(OBUF_DEPTH);

   logic [DATA_W-1:0]     e0_q, e0_d;
   logic [DATA_W-1:0]     e1_q, e1_d;
   logic [OBUF_CNT_W-1:0] cnt_q, cnt_d;
   logic                  pop_ok;
   logic                  push_ok;

   // Never pop an empty buffer; never push into a full one unless it pops too.
   assign pop_ok  = pop & (cnt_q != '0);
   assign push_ok = push & (pop_ok | (cnt_q != CNT_FULL));

   // Next-state: shift on pop, append behind the current tail on push.
   always_comb begin
      e0_d  = e0_q;
      e1_d  = e1_q;
      cnt_d = cnt_q;
      case ({push_ok, pop_ok})
         2'b10: begin
            if (cnt_q == '0) e0_d = push_data;
            else             e1_d = push_data;
            cnt_d = cnt_q + 1'b1;
         end
         2'b01: begin
            e0_d  = e1_q;
            cnt_d = cnt_q - 1'b1;
         end
         2'b11: begin
            if (cnt_q == OBUF_CNT_W'(1)) begin
               e0_d = push_data;
            end else begin
               e0_d = e1_q;
               e1_d = push_data;
            end
         end
         default: ;
      endcase
   end

   // Buffer registers with synchronous clear.
   always_ff @(posedge clk) begin
      if (clr) begin
         e0_q  <= '0;
         e1_q  <= '0;
         cnt_q <= '0;
      end else begin
         e0_q  <= e0_d;
         e1_q  <= e1_d;
         cnt_q <= cnt_d;
      end
   end

   assign head = e0_q;
   assign cnt  = cnt_q;

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller in front of an external dual-port RAM: port A writes,
// port B reads, and a 2-entry buffer gives first-word-fall-through output.
module dpram_fifo_ctrl
   import dpram_fifo_ctrl_pkg::*;
#(
   parameter int ADDR_W = FIFO_ADDR_W,
   parameter int DATA_W = FIFO_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W+1:0] level,
   output logic [ADDR_W-1:0] ram_addr_a,
   output logic [DATA_W-1:0] ram_data_a,
   output logic              ram_we_a,
   output logic [ADDR_W-1:0] ram_addr_b,
   output logic              ram_we_b,
   output logic [DATA_W-1:0] ram_data_b,
   input  logic [DATA_W-1:0] ram_q_b
);

   // ram_cnt value meaning every RAM slot is occupied (wrap bits differ).
   localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [OBUF_CNT_W:0] OCC_LIMIT = (OBUF_CNT_W+1)'(OBUF_DEPTH);

   logic [ADDR_W:0]       wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]       rd_ptr_q, rd_ptr_d;
   logic                  pend_q, pend_d;
   logic [ADDR_W+1:0]     level_q, level_d;
   logic [ADDR_W:0]       ram_cnt, ram_cnt_d;
   logic [OBUF_CNT_W-1:0] buf_cnt, buf_cnt_d;
   logic [OBUF_CNT_W:0]   occ_after;
   logic                  clr;
   logic                  push;
   logic                  pop;
   logic                  issue;

   assign clr      = ~rst_n | flush;
   assign ram_cnt  = wr_ptr_q - rd_ptr_q;
   assign wr_ready = rst_n & ~flush & (ram_cnt != FULL_CNT);
   assign push     = wr_valid & wr_ready;
   assign pop      = rd_valid & rd_ready;

   // Buffer occupancy after this edge, counting the in-flight read as landed.
   // A pop always has buf_cnt >= 1, so this never underflows.
   assign occ_after = {1'b0, buf_cnt}
                    + {{OBUF_CNT_W{1'b0}}, pend_q}
                    - {{OBUF_CNT_W{1'b0}}, pop};

   // Only read entries already counted before this edge, and only when the
   // word will have a buffer slot when it arrives one edge later.
   assign issue = (ram_cnt != '0) & (occ_after < OCC_LIMIT);

   // Pointer, pending-read and level next-state.
   always_comb begin
      wr_ptr_d  = wr_ptr_q + (ADDR_W+1)'(push);
      rd_ptr_d  = rd_ptr_q + (ADDR_W+1)'(issue);
      pend_d    = issue;
      buf_cnt_d = occ_after[OBUF_CNT_W-1:0];
      ram_cnt_d = wr_ptr_d - rd_ptr_d;
      level_d   = {1'b0, ram_cnt_d}
                + (ADDR_W+2)'(pend_d)
                + (ADDR_W+2)'(buf_cnt_d);
   end

   // State registers; reset and flush both discard everything, including a
   // read already in flight.
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         pend_q   <= 1'b0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         pend_q   <= pend_d;
         level_q  <= level_d;
      end
   end

   fifo_out_buf #(
      .DATA_W (DATA_W)
   ) u_obuf (
      .clk       (clk),
      .clr       (clr),
      .push      (pend_q),
      .push_data (ram_q_b),
      .pop       (pop),
      .head      (rd_data),
      .cnt       (buf_cnt)
   );

   assign rd_valid   = (buf_cnt != '0);
   assign level      = level_q;
   assign ram_addr_a = wr_ptr_q[ADDR_W-1:0];
   assign ram_data_a = wr_data;
   assign ram_we_a   = push;
   assign ram_addr_b = rd_ptr_q[ADDR_W-1:0];
   assign ram_we_b   = 1'b0;
   assign ram_data_b = '0;

endmodule

// File: doc/dpram_fifo_ctrl.md
# dpram_fifo_ctrl

- Synchronous FIFO controller that sits directly upstream of the 64×8 dual-port RAM.
- Turns a valid/ready write stream and a valid/ready read stream into RAM port A writes and port B reads.
- Hides the RAM's one-cycle registered read latency behind a 2-entry output buffer, giving first-word-fall-through output at one word per cycle.
- The RAM is instantiated beside this block, not inside it.

## Interface
Parameters:
- ADDR_W, 6, RAM address width; DEPTH = 2**ADDR_W (64)
- DATA_W, 8, word width

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- flush  in  1  synchronous clear of all contents; pointers and buffer emptied
- wr_valid  in  1  write request
- wr_ready  out  1  space available in RAM
- wr_data  in  DATA_W  write word
- rd_valid  out  1  rd_data holds the oldest word
- rd_ready  in  1  consumer accepts rd_data
- rd_data  out  DATA_W  head word
- level  out  ADDR_W+2  total words held (RAM + in-flight + buffer), 0..DEPTH+2
- ram_addr_a  out  ADDR_W  equals wr_ptr[ADDR_W-1:0]
- ram_data_a  out  DATA_W  equals wr_data
- ram_we_a  out  1  equals wr_valid & wr_ready
- ram_addr_b  out  ADDR_W  equals rd_ptr[ADDR_W-1:0]
- ram_we_b  out  1  tied 0
- ram_data_b  out  DATA_W  tied 0
- ram_q_b  in  DATA_W  RAM port B registered read data

## Operation
- **Pointers:** wr_ptr and rd_ptr are ADDR_W+1 bits with a wrap bit. ram_cnt = wr_ptr − rd_ptr, modulo 2^(ADDR_W+1).
- **Write side:**
  - wr_ready = rst_n & ~flush & (ram_cnt != DEPTH).
  - A push occurs when wr_valid & wr_ready; wr_ptr then increments.
  - When the RAM is full, wr_valid is ignored. There is no overwrite.
- **Read issue:**
  - issue = (ram_cnt != 0) & (buf_cnt + pend − pop < 2), where pop = rd_valid & rd_ready.
  - On issue: rd_ptr increments and pend is set to 1 at the same edge. Otherwise pend is cleared.
  - ram_addr_b is always rd_ptr. Non-issue cycles read harmlessly.
- **Capture:** when pend = 1, ram_q_b is written into the output buffer at the next edge.
- **Output buffer (2 entries):**
  - rd_valid = (buf_cnt != 0); rd_data = buffer head.
  - A capture and a pop in the same cycle keep buf_cnt unchanged.
- **Same-edge write/issue:**
  - Never the same address: issue only reads entries counted before the edge.
  - The RAM's read-old-data behaviour is therefore never exercised.
- **level** = ram_cnt + pend + buf_cnt, registered and updated every edge.
- **Reset (rst_n low at an edge) and flush (high at an edge)** have identical effect:
  - wr_ptr = rd_ptr = 0, pend = 0, buf_cnt = 0, level = 0, rd_valid = 0.
  - A read in flight is discarded.
  - Reset takes priority over push and pop in the same cycle.

## Timing
- **Reset values:** rd_valid 0, level 0, rd_data 0, ram_addr_a 0, ram_addr_b 0.
- **wr_ready** is 0 while rst_n is low and 1 in the first cycle after release.
- **Write-to-read latency:** a word pushed at edge E0 makes rd_valid go high after edge E2, i.e. two cycles later into an empty FIFO.
- **Throughput:** one push and one pop per cycle sustained indefinitely with rd_ready held high, and no bubbles once primed.
- **Backpressure:** with rd_ready low, at most 2 words leave the RAM (buffer full). All remaining words stay in the RAM.
- **wr_ready** falls in the cycle after the push that makes ram_cnt = DEPTH. It rises in the cycle after the issue that frees a slot.
- **Wrap-around:** pointer LSBs roll 63→0. The wrap bit distinguishes full from empty.

## Structure
- Shared include holds the FIFO constants: default ADDR_W, DATA_W, and buffer depth 2.
- One sub-module, fifo_out_buf:
  - 2-entry register buffer with push, pop, head, and count.
  - Synchronous clear driven by ~rst_n | flush.
- Pointer/issue logic stays in dpram_fifo_ctrl.
- The bench instantiates dpram_fifo_ctrl plus the 64×8 dual-port RAM as DUT.

## Test plan
- **Single word:** reset, then push 0xA5 at cycle 0 → rd_valid=1 two cycles later with rd_data=0xA5, level=1; pop → level=0, rd_valid=0.
- **Fill:** rd_ready=0, push 0x00..0x45 continuously → after 66 pushes, level=66, wr_ready=0, and the 67th push is ignored. Drain with rd_ready=1 → reads 0x00..0x41 in order, one per cycle.
- **Streaming:** 200 words with wr_valid=1 and rd_ready=1 every cycle → exact in-order sequence, no bubbles after the first output, pointers wrap 3×.
- **Random backpressure:** random wr_valid/rd_ready at 50%, 1000 words → scoreboard matches and level never exceeds 66.
- **Flush mid-stream:** flush with 10 words stored and a read pending → next cycle level=0, rd_valid=0. Pushing 0x3C afterwards returns 0x3C first.
- **Reset during full, with wr_valid=1:** rst_n low for 1 cycle → all state cleared, no write occurs that cycle, wr_ready=1 after release.
